// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS controller
// State, mux-select, ALU and opcode constants plus the one-hot instruction class layout.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_REG = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BZEAL = 6'b111111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Bit positions inside the one-hot class vector; an all-zero vector means illegal.
  localparam int NUM_CLS   = 12;
  localparam int CLS_ADDU  = 0;
  localparam int CLS_SUBU  = 1;
  localparam int CLS_XOR   = 2;
  localparam int CLS_JR    = 3;
  localparam int CLS_ORI   = 4;
  localparam int CLS_LUI   = 5;
  localparam int CLS_LW    = 6;
  localparam int CLS_SW    = 7;
  localparam int CLS_BEQ   = 8;
  localparam int CLS_J     = 9;
  localparam int CLS_JAL   = 10;
  localparam int CLS_BZEAL = 11;

  typedef logic [NUM_CLS-1:0] cls_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_rtype(input cls_t c);
    return c[CLS_ADDU] | c[CLS_SUBU] | c[CLS_XOR];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - op/fun to one-hot instruction class decoder
// Purely combinational; fun is only consulted for R-type opcodes.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fun_i,
  output cls_t       cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (fun_i)
          FN_ADDU: cls_o[CLS_ADDU] = 1'b1;
          FN_SUBU: cls_o[CLS_SUBU] = 1'b1;
          FN_XOR:  cls_o[CLS_XOR]  = 1'b1;
          FN_JR:   cls_o[CLS_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:   cls_o[CLS_ORI]   = 1'b1;
      OP_LUI:   cls_o[CLS_LUI]   = 1'b1;
      OP_LW:    cls_o[CLS_LW]    = 1'b1;
      OP_SW:    cls_o[CLS_SW]    = 1'b1;
      OP_BEQ:   cls_o[CLS_BEQ]   = 1'b1;
      OP_J:     cls_o[CLS_J]     = 1'b1;
      OP_JAL:   cls_o[CLS_JAL]   = 1'b1;
      OP_BZEAL: cls_o[CLS_BZEAL] = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = ~|cls_o;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle IF/ID/EXE/MEM/WB controller for the MIPS datapath
// Outputs decode the state and the class registered in S_ID; all outputs are held low in reset.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  input  logic       zero,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       instr_done,
  output logic       illegal
);

  state_e state_q, state_d;
  cls_t   cls_q, cls_d, dec_cls, cls;
  logic   dec_illegal;
  logic   taken_q, taken_d;
  ctrl_t  ctrl_raw, ctrl;

  mc_decode u_decode (
    .op_i      (op),
    .fun_i     (fun),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  // The class register only becomes valid after S_ID, so S_ID uses the decoder directly.
  assign cls = (state_q == S_ID) ? dec_cls : cls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cls_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    taken_d = taken_q;
    case (state_q)
      S_IF: if (imem_ack) state_d = S_ID;
      S_ID: begin
        cls_d = dec_cls;
        if (dec_cls[CLS_J] | dec_cls[CLS_JR] | dec_illegal) state_d = S_IF;
        else if (dec_cls[CLS_JAL])                           state_d = S_WB;
        else                                                 state_d = S_EXE;
      end
      S_EXE: begin
        if (cls_q[CLS_BZEAL]) taken_d = zero;
        if (cls_q[CLS_LW] | cls_q[CLS_SW]) state_d = S_MEM;
        else if (cls_q[CLS_BEQ])           state_d = S_IF;
        else if (cls_q[CLS_BZEAL])         state_d = zero ? S_WB : S_IF;
        else                               state_d = S_WB;
      end
      S_MEM: if (dmem_ack) state_d = cls_q[CLS_LW] ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    ctrl_raw = '0;
    case (state_q)
      S_IF: begin
        ctrl_raw.imem_req = 1'b1;
        if (imem_ack) begin
          ctrl_raw.ir_wr   = 1'b1;
          ctrl_raw.pc_wr   = 1'b1;
          ctrl_raw.npc_sel = NPC_PC4;
        end
      end
      S_ID: begin
        if (cls[CLS_J] | cls[CLS_JAL]) begin
          ctrl_raw.pc_wr   = 1'b1;
          ctrl_raw.npc_sel = NPC_JMP;
        end
        if (cls[CLS_JR]) begin
          ctrl_raw.pc_wr   = 1'b1;
          ctrl_raw.npc_sel = NPC_REG;
        end
        ctrl_raw.illegal    = dec_illegal;
        ctrl_raw.instr_done = cls[CLS_J] | cls[CLS_JR] | dec_illegal;
      end
      S_EXE: begin
        if (cls[CLS_SUBU]) ctrl_raw.alu_op = ALU_SUB;
        if (cls[CLS_XOR])  ctrl_raw.alu_op = ALU_XOR;
        if (cls[CLS_ORI]) begin
          ctrl_raw.alu_op    = ALU_OR;
          ctrl_raw.alu_src_b = 1'b1;
        end
        if (cls[CLS_LUI]) begin
          ctrl_raw.alu_op    = ALU_LUI;
          ctrl_raw.alu_src_b = 1'b1;
        end
        if (cls[CLS_LW] | cls[CLS_SW]) begin
          ctrl_raw.alu_op    = ALU_ADD;
          ctrl_raw.alu_src_b = 1'b1;
          ctrl_raw.ext_op    = 1'b1;
        end
        if (cls[CLS_BEQ] | cls[CLS_BZEAL]) begin
          ctrl_raw.alu_op = ALU_SUB;
          if (zero) begin
            ctrl_raw.pc_wr   = 1'b1;
            ctrl_raw.npc_sel = NPC_BR;
          end
        end
        ctrl_raw.instr_done = cls[CLS_BEQ] | (cls[CLS_BZEAL] & ~zero);
      end
      S_MEM: begin
        ctrl_raw.dmem_req   = 1'b1;
        ctrl_raw.dmem_we    = cls[CLS_SW];
        ctrl_raw.instr_done = dmem_ack & cls[CLS_SW];
      end
      S_WB: begin
        ctrl_raw.reg_wr     = ~(cls[CLS_BZEAL] & ~taken_q);
        ctrl_raw.instr_done = 1'b1;
        if (is_rtype(cls)) begin
          ctrl_raw.reg_dst = DST_RD;
          ctrl_raw.wd_sel  = WD_ALU;
        end else if (cls[CLS_LW]) begin
          ctrl_raw.reg_dst = DST_RT;
          ctrl_raw.wd_sel  = WD_MEM;
        end else if (cls[CLS_JAL] | cls[CLS_BZEAL]) begin
          ctrl_raw.reg_dst = DST_RA;
          ctrl_raw.wd_sel  = WD_PC4;
        end
      end
      default: ;
    endcase
  end

  assign ctrl = reset ? ctrl_raw : '0;

  assign imem_req   = ctrl.imem_req;
  assign dmem_req   = ctrl.dmem_req;
  assign dmem_we    = ctrl.dmem_we;
  assign pc_wr      = ctrl.pc_wr;
  assign npc_sel    = ctrl.npc_sel;
  assign ir_wr      = ctrl.ir_wr;
  assign reg_wr     = ctrl.reg_wr;
  assign reg_dst    = ctrl.reg_dst;
  assign wd_sel     = ctrl.wd_sel;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign ext_op     = ctrl.ext_op;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm
// Table vectors, hand-written reset sequences and random instructions against a phase-list model.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0, fun = '0;
  logic       zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, pc_wr, ir_wr, reg_wr;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic       alu_src_b, ext_op, instr_done, illegal;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .op(op), .fun(fun), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       ia;
    logic       da;
    logic       z;
    logic [5:0] op;
    logic [5:0] fun;
    outs_t      exp;
  } cyc_t;

  typedef struct {
    int k; int z; int iw; int dw;
    int cyc; int regwr; int pcwr; int dreq; int ill;
  } vec_t;

  // Instruction indices: 0 addu 1 subu 2 xor 3 jr 4 ori 5 lui 6 lw 7 sw 8 beq 9 j 10 jal 11 bzeal 12/13 illegal
  localparam int NK = 14;
  logic [5:0] ops  [NK] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                            6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b111111, 6'b110011, 6'b000000};
  logic [5:0] funs [NK] = '{6'b100001, 6'b100011, 6'b100110, 6'b001000, 6'b0, 6'b0, 6'b0,
                            6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b111111};

  int   n_chk = 0;
  int   n_fail = 0;
  cyc_t q[$];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input outs_t got, input outs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic outs_t sample();
    outs_t s;
    s.imem_req = imem_req;   s.dmem_req = dmem_req;   s.dmem_we = dmem_we;
    s.pc_wr = pc_wr;         s.npc_sel = npc_sel;     s.ir_wr = ir_wr;
    s.reg_wr = reg_wr;       s.reg_dst = reg_dst;     s.wd_sel = wd_sel;
    s.alu_src_b = alu_src_b; s.alu_op = alu_op;       s.ext_op = ext_op;
    s.instr_done = instr_done; s.illegal = illegal;
    return s;
  endfunction

  function automatic cyc_t rnd_cyc();
    cyc_t c;
    c.ia  = ($urandom_range(0, 1) == 1);
    c.da  = ($urandom_range(0, 1) == 1);
    c.z   = ($urandom_range(0, 1) == 1);
    c.op  = 6'($urandom_range(0, 63));
    c.fun = 6'($urandom_range(0, 63));
    c.exp = '0;
    return c;
  endfunction

  // Expected cycle list for one instruction, phase by phase.
  function automatic void build(input int k, input logic z, input int iw, input int dw);
    cyc_t c;
    q.delete();
    for (int w = 0; w <= iw; w++) begin
      c = rnd_cyc();
      c.ia = (w == iw);
      c.exp.imem_req = 1'b1;
      if (c.ia) begin c.exp.ir_wr = 1'b1; c.exp.pc_wr = 1'b1; end
      q.push_back(c);
    end
    c = rnd_cyc();
    c.op = ops[k];
    if (k <= 3 || k == 13) c.fun = funs[k];
    case (k)
      3:       begin c.exp.pc_wr = 1'b1; c.exp.npc_sel = 2'd3; c.exp.instr_done = 1'b1; end
      9:       begin c.exp.pc_wr = 1'b1; c.exp.npc_sel = 2'd2; c.exp.instr_done = 1'b1; end
      10:      begin c.exp.pc_wr = 1'b1; c.exp.npc_sel = 2'd2; end
      12, 13:  begin c.exp.illegal = 1'b1; c.exp.instr_done = 1'b1; end
      default: ;
    endcase
    q.push_back(c);
    if (k == 3 || k == 9 || k == 12 || k == 13) return;
    if (k != 10) begin
      c = rnd_cyc();
      c.z = z;
      case (k)
        1:       c.exp.alu_op = 3'd1;
        2:       c.exp.alu_op = 3'd3;
        4:       begin c.exp.alu_op = 3'd2; c.exp.alu_src_b = 1'b1; end
        5:       begin c.exp.alu_op = 3'd4; c.exp.alu_src_b = 1'b1; end
        6, 7:    begin c.exp.alu_src_b = 1'b1; c.exp.ext_op = 1'b1; end
        8:       begin c.exp.alu_op = 3'd1; c.exp.instr_done = 1'b1;
                       if (z) begin c.exp.pc_wr = 1'b1; c.exp.npc_sel = 2'd1; end end
        11:      begin c.exp.alu_op = 3'd1;
                       if (z) begin c.exp.pc_wr = 1'b1; c.exp.npc_sel = 2'd1; end
                       else c.exp.instr_done = 1'b1; end
        default: ;
      endcase
      q.push_back(c);
      if (k == 8 || (k == 11 && !z)) return;
      if (k == 6 || k == 7) begin
        for (int w = 0; w <= dw; w++) begin
          c = rnd_cyc();
          c.da = (w == dw);
          c.exp.dmem_req = 1'b1;
          c.exp.dmem_we = (k == 7);
          c.exp.instr_done = c.da && (k == 7);
          q.push_back(c);
        end
        if (k == 7) return;
      end
    end
    c = rnd_cyc();
    c.exp.reg_wr = 1'b1;
    c.exp.instr_done = 1'b1;
    if (k <= 2)                 begin c.exp.reg_dst = 2'd1; c.exp.wd_sel = 2'd0; end
    else if (k == 6)            begin c.exp.reg_dst = 2'd0; c.exp.wd_sel = 2'd1; end
    else if (k == 10 || k == 11) begin c.exp.reg_dst = 2'd2; c.exp.wd_sel = 2'd2; end
    q.push_back(c);
  endfunction

  // Entered #1 after a rising edge; leaves #3 after it with outputs sampled.
  task automatic play(input cyc_t c, input string name, output outs_t got);
    imem_ack = c.ia; dmem_ack = c.da; zero = c.z; op = c.op; fun = c.fun;
    #2;
    got = sample();
    chk_outs(name, got, c.exp);
  endtask

  task automatic run(input int k, input int z, input int iw, input int dw,
                     output int cyc, output int regwr, output int pcwr,
                     output int dreq, output int ill, output int dn);
    outs_t got;
    build(k, (z != 0), iw, dw);
    cyc = 0; regwr = 0; pcwr = 0; dreq = 0; ill = 0; dn = 0;
    for (int i = 0; i < q.size(); i++) begin
      play(q[i], $sformatf("k%0d cycle%0d", k, i), got);
      if (got.reg_wr) regwr++;
      if (got.pc_wr) pcwr++;
      if (got.dmem_req) dreq++;
      if (got.illegal) ill++;
      if (got.instr_done) begin dn++; if (cyc == 0) cyc = i + 1; end
      @(posedge clk);
      #1;
    end
  endtask

  vec_t  tbl[16];
  outs_t got, exp_o;
  int    cyc, regwr, pcwr, dreq, ill, dn;

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 4, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 5, 1, 1, 0, 0};
    tbl[2]  = '{2, 1, 0, 0, 4, 1, 1, 0, 0};
    tbl[3]  = '{3, 0, 0, 0, 2, 0, 2, 0, 0};
    tbl[4]  = '{4, 0, 2, 0, 6, 1, 1, 0, 0};
    tbl[5]  = '{5, 0, 0, 0, 4, 1, 1, 0, 0};
    tbl[6]  = '{6, 0, 0, 3, 8, 1, 1, 4, 0};
    tbl[7]  = '{7, 0, 0, 0, 4, 0, 1, 1, 0};
    tbl[8]  = '{8, 1, 0, 0, 3, 0, 2, 0, 0};
    tbl[9]  = '{8, 0, 0, 0, 3, 0, 1, 0, 0};
    tbl[10] = '{9, 0, 0, 0, 2, 0, 2, 0, 0};
    tbl[11] = '{10, 0, 0, 0, 3, 1, 2, 0, 0};
    tbl[12] = '{11, 1, 0, 0, 4, 1, 2, 0, 0};
    tbl[13] = '{11, 0, 0, 0, 3, 0, 1, 0, 0};
    tbl[14] = '{12, 0, 0, 0, 2, 0, 1, 0, 1};
    tbl[15] = '{13, 0, 0, 0, 2, 0, 1, 0, 1};

    // Reset held: every output low even though the state is S_IF.
    repeat (2) @(posedge clk);
    #1;
    imem_ack = 1'b1;
    #1;
    chk_outs("in_reset", sample(), '0);
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    exp_o = '0; exp_o.imem_req = 1'b1;
    chk_outs("after_reset_if", sample(), exp_o);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run(tbl[i].k, tbl[i].z, tbl[i].iw, tbl[i].dw, cyc, regwr, pcwr, dreq, ill, dn);
      chk($sformatf("tbl%0d cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d reg_wr", i), regwr, tbl[i].regwr);
      chk($sformatf("tbl%0d pc_wr", i), pcwr, tbl[i].pcwr);
      chk($sformatf("tbl%0d dmem_req", i), dreq, tbl[i].dreq);
      chk($sformatf("tbl%0d illegal", i), ill, tbl[i].ill);
      chk($sformatf("tbl%0d done_count", i), dn, 1);
    end

    // Reset during the S_MEM wait of a store: everything drops at once, restart in S_IF.
    build(7, 1'b0, 0, 10);
    for (int i = 0; i < 4; i++) begin
      play(q[i], $sformatf("sw_abort cycle%0d", i), got);
      if (i < 3) begin @(posedge clk); #1; end
    end
    chk("sw_abort dmem_req_before", int'(got.dmem_req), 1);
    reset = 1'b0;
    #1;
    chk_outs("sw_abort in_reset", sample(), '0);
    @(posedge clk);
    #1;
    imem_ack = 1'b0; dmem_ack = 1'b1;
    #1;
    chk_outs("sw_abort held_reset", sample(), '0);
    reset = 1'b1;
    dmem_ack = 1'b0;
    #1;
    exp_o = '0; exp_o.imem_req = 1'b1;
    chk_outs("sw_abort restart_if", sample(), exp_o);
    @(posedge clk);
    #1;

    for (int n = 0; n < 80; n++) begin
      int k, z, iw, dw;
      k  = $urandom_range(0, NK - 1);
      z  = $urandom_range(0, 1);
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      run(k, z, iw, dw, cyc, regwr, pcwr, dreq, ill, dn);
      chk($sformatf("rnd%0d done_count", n), dn, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
